// File: rtl/rate_div_pkg.sv
// Shared definitions for the multi-rate divider.
//   MODE_PULSE / MODE_TOGGLE : values carried on cfg_mode
//   DEFAULT_DIV_60HZ         : 50 MHz / 60, used as the reset divisor
package rate_div_pkg;

  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

  localparam int DEFAULT_DIV_60HZ = 833333;

endpackage

// File: rtl/rate_div_channel.sv
// One divider channel: a down-counter that ticks once every `div` enabled
// cycles, an optional toggled square-wave output, and a one-deep pending
// configuration slot that is only applied at a period boundary.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   en_i                count enable
//   sync_restart_i      restart this channel in phase with the others
//   cfg_we_i            store cfg_div_i/cfg_mode_i as pending (accepted transfer)
//   cfg_div_i           new divisor (0 behaves as 1)
//   cfg_mode_i          new mode (MODE_PULSE / MODE_TOGGLE)
//   pend_o              pending slot occupied
//   tick_o              registered one-cycle pulse per period
//   clkout_o            registered square wave (toggle mode), 0 in pulse mode
module rate_div_channel
  import rate_div_pkg::*;
#(
  parameter int WIDTH       = 23,
  parameter int DEFAULT_DIV = DEFAULT_DIV_60HZ
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sync_restart_i,
  input  logic             cfg_we_i,
  input  logic [WIDTH-1:0] cfg_div_i,
  input  logic             cfg_mode_i,
  output logic             pend_o,
  output logic             tick_o,
  output logic             clkout_o
);

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] RST_CNT = (RST_DIV == '0) ? '0 : RST_DIV - 1'b1;

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             mode_q, mode_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_mode_q, pend_mode_d;
  logic             tick_q, tick_d;
  logic             clkout_q, clkout_d;

  logic             apply;
  logic [WIDTH-1:0] new_div;
  logic             new_mode;
  logic [WIDTH-1:0] reload_cnt;
  logic             mode_chg;

  always_comb begin
    // Pending config is consumed at any reload point: terminal count while
    // enabled, any edge while disabled, or a synchronous restart.
    apply      = pend_q & (sync_restart_i | ~en_i | (count_q == '0));
    new_div    = apply ? pend_div_q  : div_q;
    new_mode   = apply ? pend_mode_q : mode_q;
    // A divisor of 0 is treated as 1, i.e. reload to 0 and tick every cycle.
    reload_cnt = (new_div == '0) ? '0 : new_div - 1'b1;
    mode_chg   = apply & (pend_mode_q != mode_q);

    count_d     = count_q;
    div_d       = new_div;
    mode_d      = new_mode;
    pend_d      = pend_q & ~apply;
    pend_div_d  = pend_div_q;
    pend_mode_d = pend_mode_q;
    tick_d      = 1'b0;
    clkout_d    = clkout_q;

    if (sync_restart_i) begin
      count_d  = reload_cnt;
      clkout_d = 1'b0;
    end else if (en_i) begin
      if (count_q == '0) begin
        count_d  = reload_cnt;
        tick_d   = 1'b1;
        clkout_d = (mode_chg || new_mode == MODE_PULSE) ? 1'b0 : ~clkout_q;
      end else begin
        count_d = count_q - 1'b1;
      end
    end else if (apply) begin
      count_d = reload_cnt;
      if (mode_chg) begin
        clkout_d = 1'b0;
      end
    end

    // The top only asserts cfg_we_i while the slot is empty, so this can
    // never collide with an apply in the same cycle.
    if (cfg_we_i) begin
      pend_d      = 1'b1;
      pend_div_d  = cfg_div_i;
      pend_mode_d = cfg_mode_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q     <= RST_CNT;
      div_q       <= RST_DIV;
      mode_q      <= MODE_TOGGLE;
      pend_q      <= 1'b0;
      pend_div_q  <= '0;
      pend_mode_q <= MODE_PULSE;
      tick_q      <= 1'b0;
      clkout_q    <= 1'b0;
    end else begin
      count_q     <= count_d;
      div_q       <= div_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      pend_div_q  <= pend_div_d;
      pend_mode_q <= pend_mode_d;
      tick_q      <= tick_d;
      clkout_q    <= clkout_d;
    end
  end

  assign pend_o   = pend_q;
  assign tick_o   = tick_q;
  assign clkout_o = clkout_q;

endmodule

// File: rtl/multi_rate_divider.sv
// Bank of independent clock dividers sharing one configuration port.
// Ports:
//   clkin, resetn        clock, asynchronous active-low reset
//   en[CHANNELS]         per-channel count enable
//   sync_restart         restart every channel in phase
//   cfg_valid/cfg_ready  configuration handshake; ready = target slot free
//   cfg_chan             target channel (codes >= CHANNELS are accepted, dropped)
//   cfg_div, cfg_mode    new divisor (cycles per tick) and mode
//   tick[CHANNELS]       one-cycle pulse per period
//   clkout[CHANNELS]     square wave of period 2*div in toggle mode
module multi_rate_divider
  import rate_div_pkg::*;
#(
  parameter  int CHANNELS    = 4,
  parameter  int WIDTH       = 23,
  parameter  int DEFAULT_DIV = DEFAULT_DIV_60HZ,
  localparam int CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clkin,
  input  logic                resetn,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync_restart,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic                cfg_mode,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] clkout
);

  logic [CHANNELS-1:0] sel;
  logic [CHANNELS-1:0] pend;

  // An out-of-range cfg_chan selects nothing, so it reads as ready and the
  // transfer writes no channel.
  assign cfg_ready = ~|(sel & pend);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    assign sel[gi] = (cfg_chan == CHAN_W'(gi));

    rate_div_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_i          (clkin),
      .rst_ni         (resetn),
      .en_i           (en[gi]),
      .sync_restart_i (sync_restart),
      .cfg_we_i       (cfg_valid & sel[gi] & ~pend[gi]),
      .cfg_div_i      (cfg_div),
      .cfg_mode_i     (cfg_mode),
      .pend_o         (pend[gi]),
      .tick_o         (tick[gi]),
      .clkout_o       (clkout[gi])
    );
  end

endmodule

// File: tb/tb_multi_rate_divider.sv
module tb_multi_rate_divider;

  // Three channels so that cfg_chan has one code with no channel behind it.
  localparam int CH  = 3;
  localparam int W   = 8;
  localparam int DEF = 4;
  localparam int CW  = 2;

  logic          clkin = 1'b0;
  logic          resetn = 1'b0;
  logic [CH-1:0] en = '0;
  logic          sync_restart = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan = '0;
  logic [W-1:0]  cfg_div = '0;
  logic          cfg_mode = 1'b0;
  logic [CH-1:0] tick;
  logic [CH-1:0] clkout;

  int compared = 0;
  int mismatched = 0;

  always #5 clkin = ~clkin;

  multi_rate_divider #(
    .CHANNELS    (CH),
    .WIDTH       (W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clkin        (clkin),
    .resetn       (resetn),
    .en           (en),
    .sync_restart (sync_restart),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_chan     (cfg_chan),
    .cfg_div      (cfg_div),
    .cfg_mode     (cfg_mode),
    .tick         (tick),
    .clkout       (clkout)
  );

  // Reference model: each channel counts enabled edges elapsed in the current
  // period and ticks when that reaches the period length.
  int m_per[CH];
  int m_phase[CH];
  bit m_tog[CH];
  bit m_pv[CH];
  int m_pd[CH];
  bit m_pm[CH];
  bit m_out[CH];
  bit m_tick[CH];
  bit m_xfer[CH];
  bit m_chg;

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic bit exp_ready(input int c);
    if (c >= CH) return 1'b1;
    return !m_pv[c];
  endfunction

  always @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CH; i++) begin
        m_per[i] = DEF; m_phase[i] = 0; m_tog[i] = 1'b1; m_pv[i] = 1'b0;
        m_pd[i] = 0; m_pm[i] = 1'b0; m_out[i] = 1'b0; m_tick[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < CH; i++)
        m_xfer[i] = cfg_valid && (int'(cfg_chan) == i) && !m_pv[i];
      for (int i = 0; i < CH; i++) begin
        m_chg = 1'b0;
        m_tick[i] = 1'b0;
        if (sync_restart) begin
          if (m_pv[i]) begin
            m_per[i] = eff(m_pd[i]); m_tog[i] = m_pm[i]; m_pv[i] = 1'b0;
          end
          m_phase[i] = 0;
          m_out[i] = 1'b0;
        end else if (en[i]) begin
          m_phase[i]++;
          if (m_phase[i] >= m_per[i]) begin
            m_phase[i] = 0;
            m_tick[i] = 1'b1;
            if (m_pv[i]) begin
              m_chg = (m_pm[i] != m_tog[i]);
              m_per[i] = eff(m_pd[i]); m_tog[i] = m_pm[i]; m_pv[i] = 1'b0;
            end
            m_out[i] = (m_chg || !m_tog[i]) ? 1'b0 : !m_out[i];
          end
        end else if (m_pv[i]) begin
          m_chg = (m_pm[i] != m_tog[i]);
          m_per[i] = eff(m_pd[i]); m_tog[i] = m_pm[i]; m_pv[i] = 1'b0;
          m_phase[i] = 0;
          if (m_chg) m_out[i] = 1'b0;
        end
        if (m_xfer[i]) begin
          m_pv[i] = 1'b1; m_pd[i] = int'(cfg_div); m_pm[i] = cfg_mode;
        end
      end
    end
  end

  // Drives one cycle of inputs, checks the combinational ready before the
  // edge and the registered outputs half a cycle after it.
  task automatic step(input logic [CH-1:0] e, input logic s, input logic v,
                      input int c, input int d, input logic m);
    logic [CH-1:0] exp_t;
    logic [CH-1:0] exp_c;
    bit            rdy;
    en = e; sync_restart = s; cfg_valid = v;
    cfg_chan = CW'(c); cfg_div = W'(d); cfg_mode = m;
    #1;
    rdy = exp_ready(c);
    compared++;
    if (cfg_ready !== rdy) begin
      mismatched++;
      $display("FAIL cfg_ready ch=%0d got=%b want=%b t=%0t", c, cfg_ready, rdy, $time);
    end
    if (v && rdy) $display("cfg transfer ch=%0d div=%0d mode=%0d t=%0t", c, d, m, $time);
    @(posedge clkin);
    @(negedge clkin);
    for (int i = 0; i < CH; i++) begin
      exp_t[i] = m_tick[i];
      exp_c[i] = m_out[i];
    end
    compared++;
    if (tick !== exp_t) begin
      mismatched++;
      $display("FAIL tick got=%b want=%b t=%0t", tick, exp_t, $time);
    end
    compared++;
    if (clkout !== exp_c) begin
      mismatched++;
      $display("FAIL clkout got=%b want=%b t=%0t", clkout, exp_c, $time);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; en = '0; sync_restart = 1'b0; cfg_valid = 1'b0;
    @(negedge clkin);
    @(negedge clkin);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; cfg_chan = '0;
    @(negedge clkin);
    compared++;
    if (tick !== '0) begin
      mismatched++; $display("FAIL reset_tick got=%b want=0", tick);
    end
    compared++;
    if (clkout !== '0) begin
      mismatched++; $display("FAIL reset_clkout got=%b want=0", clkout);
    end
    compared++;
    if (cfg_ready !== 1'b1) begin
      mismatched++; $display("FAIL reset_ready got=%b want=1", cfg_ready);
    end
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    bit exp_b;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step('1, 1'b0, 1'b0, 0, 0, 1'b0);
      exp_b = (k % 4 == 0);
      compared++;
      if (tick[0] !== exp_b || tick[1] !== exp_b) begin
        mismatched++; $display("FAIL basic_tick edge=%0d got=%b want=%b", k, tick[1:0], {exp_b, exp_b});
      end
      exp_b = ((k / 4) % 2 == 1);
      compared++;
      if (clkout[0] !== exp_b) begin
        mismatched++; $display("FAIL basic_clkout edge=%0d got=%b want=%b", k, clkout[0], exp_b);
      end
    end
  endtask

  task automatic test_cfg_reload();
    bit exp_b;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step('1, 1'b0, (k == 2), 0, 6, 1'b1);
      exp_b = (k == 4 || k == 10 || k == 16);
      compared++;
      if (tick[0] !== exp_b) begin
        mismatched++; $display("FAIL reload_tick edge=%0d got=%b want=%b", k, tick[0], exp_b);
      end
      if (k <= 5) begin
        cfg_valid = 1'b0; cfg_chan = 0; #1;
        exp_b = !(k == 2 || k == 3);
        compared++;
        if (cfg_ready !== exp_b) begin
          mismatched++; $display("FAIL reload_ready0 edge=%0d got=%b want=%b", k, cfg_ready, exp_b);
        end
        cfg_chan = 1; #1;
        compared++;
        if (cfg_ready !== 1'b1) begin
          mismatched++; $display("FAIL reload_ready1 edge=%0d got=%b want=1", k, cfg_ready);
        end
      end
    end
  endtask

  task automatic test_disable();
    bit exp_b;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      step((k >= 2 && k <= 5) ? 3'b101 : 3'b111, 1'b0, 1'b0, 0, 0, 1'b0);
      exp_b = (k == 8);
      compared++;
      if (tick[1] !== exp_b) begin
        mismatched++; $display("FAIL disable_tick edge=%0d got=%b want=%b", k, tick[1], exp_b);
      end
      exp_b = (k >= 8);
      compared++;
      if (clkout[1] !== exp_b) begin
        mismatched++; $display("FAIL disable_clkout edge=%0d got=%b want=%b", k, clkout[1], exp_b);
      end
    end
  endtask

  task automatic test_div0();
    logic prev;
    prev = 1'b0;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      step('1, 1'b0, (k == 1 || k == 5), 0, (k == 1) ? 0 : 1, 1'b1);
      if (k >= 5) begin
        compared++;
        if (tick[0] !== 1'b1) begin
          mismatched++; $display("FAIL div0_tick edge=%0d got=%b want=1", k, tick[0]);
        end
        compared++;
        if (clkout[0] !== ~prev) begin
          mismatched++; $display("FAIL div0_clkout edge=%0d got=%b want=%b", k, clkout[0], ~prev);
        end
      end
      prev = clkout[0];
    end
  endtask

  task automatic test_mode_sync();
    logic [1:0] exp_v;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step('1, (k == 7), (k == 1 || k == 2), (k == 2) ? 1 : 0, 4, 1'b0);
      exp_v = (k == 4 || k == 11) ? 2'b11 : 2'b00;
      compared++;
      if (tick[1:0] !== exp_v) begin
        mismatched++; $display("FAIL sync_tick edge=%0d got=%b want=%b", k, tick[1:0], exp_v);
      end
      compared++;
      if (clkout[1:0] !== 2'b00) begin
        mismatched++; $display("FAIL pulse_clkout edge=%0d got=%b want=00", k, clkout[1:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit exp_b;
    do_reset();
    for (int k = 1; k <= 6; k++) step('1, 1'b0, (k == 5), 0, 2, 1'b0);
    cfg_valid = 1'b0; cfg_chan = 0;
    #2 resetn = 1'b0;
    #1;
    compared++;
    if (tick !== '0 || clkout !== '0) begin
      mismatched++; $display("FAIL midreset_out tick=%b clkout=%b want=0", tick, clkout);
    end
    compared++;
    if (cfg_ready !== 1'b1) begin
      mismatched++; $display("FAIL midreset_ready got=%b want=1", cfg_ready);
    end
    @(negedge clkin);
    @(negedge clkin);
    resetn = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step('1, 1'b0, 1'b0, 0, 0, 1'b0);
      exp_b = (k == 4);
      compared++;
      if (tick[0] !== exp_b) begin
        mismatched++; $display("FAIL midreset_tick edge=%0d got=%b want=%b", k, tick[0], exp_b);
      end
      exp_b = (k >= 4);
      compared++;
      if (clkout[0] !== exp_b) begin
        mismatched++; $display("FAIL midreset_clkout edge=%0d got=%b want=%b", k, clkout[0], exp_b);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (400) begin
      step(CH'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cfg_reload();
    test_disable();
    test_div0();
    test_mode_sync();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
